axi_mem_port_sched: RTL

//  Arbitration/sequencing controller for the shared DDR (MIG) AXI port, contended by CPU and SD-card DMA masters.

---
 rtl/soc_arb_pkg.sv | 34 +++
 rtl/sched_sel_fifo.sv | 55 +++++
 rtl/axi_mem_port_sched.sv | 139 +++++++++++++
 3 files changed

// File: rtl/soc_arb_pkg.sv
// Shared types and helpers for the DDR port scheduler: state encoding and round-robin pick.
package soc_arb_pkg;

  localparam int unsigned MAX_REQ = 16;
  localparam int unsigned IDX_W   = 4;

  typedef logic [IDX_W-1:0] req_idx_t;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  function automatic int unsigned sel_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // First set bit of valid at or after ptr, wrapping at n; returns ptr when none set.
  function automatic req_idx_t rr_pick(input logic [MAX_REQ-1:0] valid, input req_idx_t ptr,
                                       input int unsigned n);
    req_idx_t pick;
    int       idx;
    pick = ptr;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (k < int'(n)) begin
        idx = int'(ptr) + k;
        if (idx >= int'(n)) idx = idx - int'(n);
        if (valid[idx]) pick = req_idx_t'(idx);
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/sched_sel_fifo.sv
// Synchronous FIFO holding the requester index of each AW grant, in grant order.
module sched_sel_fifo #(
  parameter int unsigned  WIDTH = 1,
  parameter int unsigned  DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt_q;
  logic             do_push;
  logic             do_pop;

  // A pop frees a slot in the same cycle, so push is accepted even when full.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign full     = (cnt_q == CW'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign count    = cnt_q;
  assign pop_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/axi_mem_port_sched.sv
// Round-robin AR/AW grant controller for the shared DDR AXI port with per-requester
// outstanding caps and AW-ordered W steering.
module axi_mem_port_sched
  import soc_arb_pkg::*;
#(
  parameter int unsigned  NUM_REQ      = 2,
  parameter int unsigned  MAX_OUTST    = 4,
  parameter int unsigned  W_FIFO_DEPTH = 4,
  localparam int unsigned SEL_W        = sel_w(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_ar_valid,
  input  logic [NUM_REQ-1:0] req_aw_valid,
  input  logic               ar_hs,
  input  logic               aw_hs,
  input  logic               w_last_hs,
  input  logic               r_last_hs,
  input  logic [SEL_W-1:0]   r_src,
  input  logic               b_hs,
  input  logic [SEL_W-1:0]   b_src,
  output logic [NUM_REQ-1:0] ar_gnt,
  output logic [NUM_REQ-1:0] aw_gnt,
  output logic [SEL_W-1:0]   w_sel,
  output logic               w_sel_valid,
  output logic               idle,
  output logic               err_underflow
);

  localparam int unsigned CNT_W  = $clog2(MAX_OUTST + 1);
  localparam int unsigned FCNT_W = $clog2(W_FIFO_DEPTH) + 1;
  localparam int unsigned NCH    = 2;  // channel 0 = AR/R, channel 1 = AW/B

  logic [NCH-1:0][NUM_REQ-1:0]            valid, elig, gnt, inc, dec, uf;
  logic [NCH-1:0]                         hs, done, busy;
  logic [NCH-1:0][SEL_W-1:0]              src, win, ptr, pick;
  logic [NCH-1:0][NUM_REQ-1:0][CNT_W-1:0] cnt;
  arb_state_t                             state [NCH];
  logic                                   fifo_full, fifo_empty, fifo_push, pop_err, cnt_zero;
  logic [FCNT_W-1:0]                      fifo_count;

  assign valid = {req_aw_valid, req_ar_valid};
  assign hs    = {aw_hs, ar_hs};
  assign done  = {b_hs, r_last_hs};
  assign src   = {b_src, r_src};

  // Eligibility, counter increment/decrement strobes and round-robin choice per channel.
  always_comb begin
    elig     = '0;
    inc      = '0;
    dec      = '0;
    uf       = '0;
    busy     = '0;
    pick     = '0;
    cnt_zero = 1'b1;
    for (int unsigned c = 0; c < NCH; c++) begin
      busy[c] = (state[c] == ARB_GRANT);
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        elig[c][i] = valid[c][i] && (cnt[c][i] < CNT_W'(MAX_OUTST)) && !(c == 1 && fifo_full);
        inc[c][i]  = busy[c] && hs[c] && (win[c] == SEL_W'(i));
        dec[c][i]  = done[c] && (src[c] == SEL_W'(i));
        uf[c][i]   = dec[c][i] && !inc[c][i] && (cnt[c][i] == '0);
        if (cnt[c][i] != '0) cnt_zero = 1'b0;
      end
      pick[c] = SEL_W'(rr_pick(MAX_REQ'(elig[c]), req_idx_t'(ptr[c]), NUM_REQ));
    end
  end

  // Grant is held until the downstream handshake, then the pointer moves past the winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned c = 0; c < NCH; c++) state[c] <= ARB_IDLE;
      gnt <= '0;
      win <= '0;
      ptr <= '0;
    end else begin
      for (int unsigned c = 0; c < NCH; c++) begin
        case (state[c])
          ARB_IDLE: begin
            if (|elig[c]) begin
              gnt[c]   <= NUM_REQ'(1) << pick[c];
              win[c]   <= pick[c];
              state[c] <= ARB_GRANT;
            end
          end
          ARB_GRANT: begin
            if (hs[c]) begin
              gnt[c]   <= '0;
              ptr[c]   <= (win[c] == SEL_W'(NUM_REQ - 1)) ? '0 : win[c] + 1'b1;
              state[c] <= ARB_IDLE;
            end
          end
          default: state[c] <= ARB_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt           <= '0;
      err_underflow <= 1'b0;
    end else begin
      for (int unsigned c = 0; c < NCH; c++) begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
          if (inc[c][i] && !dec[c][i])
            cnt[c][i] <= cnt[c][i] + 1'b1;
          else if (dec[c][i] && !inc[c][i] && cnt[c][i] != '0)
            cnt[c][i] <= cnt[c][i] - 1'b1;
        end
      end
      if ((|uf) || pop_err) err_underflow <= 1'b1;
    end
  end

  assign fifo_push = busy[1] && aw_hs;
  assign pop_err   = w_last_hs && fifo_empty;

  sched_sel_fifo #(
    .WIDTH (SEL_W),
    .DEPTH (W_FIFO_DEPTH)
  ) u_aw_order (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (win[1]),
    .pop       (w_last_hs),
    .pop_data  (w_sel),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign ar_gnt      = gnt[0];
  assign aw_gnt      = gnt[1];
  assign w_sel_valid = !fifo_empty;
  assign idle        = (gnt == '0) && cnt_zero && (fifo_count == '0);

endmodule
